// File: rtl/packet_assembler_if.sv
// Byte-in / packet-out bus of the packet assembler.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid && ready; the source holds valid and its payload stable until then,
// and ready may depend combinationally on state but never on valid.
interface packet_assembler_if #(
  parameter int NUM_BYTE = 4
) ();
  localparam int LW = $clog2(NUM_BYTE + 1);

  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [8*NUM_BYTE-1:0] out_data;
  logic [LW-1:0]         out_len;
  logic                  out_valid;
  logic                  out_ready;

  // Environment side: byte producer plus packet consumer.
  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_len, out_valid
  );

  // Assembler side.
  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_len, out_valid
  );
endinterface

// File: rtl/packet_assembler.sv
// Byte-to-packet assembler: collects bytes into a NUM_BYTE packet with
// selectable byte order, emits short packets on flush or idle timeout and
// reports the number of valid bytes with each packet.
module packet_assembler #(
  parameter int NUM_BYTE    = 4,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                clk,
  input  logic                rst,
  packet_assembler_if.slave   bus,
  output logic                dbg_state
);
  localparam int CW      = $clog2(NUM_BYTE + 1);
  localparam int DW      = 8 * NUM_BYTE;
  localparam int IW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  // COLLECT: gathering bytes; FULL: packet complete, waiting for the output slot.
  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]   out_len_q, out_len_d;
  logic            out_valid_q, out_valid_d;

  logic            accept;
  logic            slot_free;
  logic [CW-1:0]   slot_idx;
  logic [DW-1:0]   acc_ins;
  logic [CW-1:0]   count_ins;
  logic            timeout_fire;
  logic            complete;

  // Accumulator view including any byte accepted this cycle, and completion triggers.
  always_comb begin
    accept    = bus.in_valid && (state_q == COLLECT);
    slot_free = !out_valid_q || bus.out_ready;
    // MSB_FIRST fills from the top slot down, so partial packets end up left-justified.
    slot_idx  = MSB_FIRST ? (CW'(NUM_BYTE - 1) - count_q) : count_q;
    acc_ins   = acc_q;
    for (int i = 0; i < NUM_BYTE; i++) begin
      if (accept && (slot_idx == CW'(i))) begin
        acc_ins[8*i +: 8] = bus.in_data;
      end
    end
    count_ins = count_q + CW'(accept);
    // Fires in the TIMEOUT_CYC-th consecutive idle cycle of a partial packet.
    timeout_fire = (TIMEOUT_CYC > 0) && (state_q == COLLECT) && (count_q != '0) &&
                   !accept && (idle_q == IW'(TO_LAST));
    complete  = (state_q == COLLECT) &&
                ((accept && (count_ins == CW'(NUM_BYTE))) ||
                 (bus.flush && (count_ins != '0)) ||
                 timeout_fire);
  end

  // Next-state, accumulator, idle counter and output register updates.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    idle_d      = idle_q;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;
    out_valid_d = out_valid_q;

    // A handshake empties the slot; a load below may refill it in the same cycle.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      COLLECT: begin
        if (complete) begin
          idle_d = '0;
          if (slot_free) begin
            out_data_d  = acc_ins;
            out_len_d   = count_ins;
            out_valid_d = 1'b1;
            acc_d       = '0;
            count_d     = '0;
          end else begin
            acc_d   = acc_ins;
            count_d = count_ins;
            state_d = FULL;
          end
        end else begin
          acc_d   = acc_ins;
          count_d = count_ins;
          if (accept || (count_q == '0) || (TIMEOUT_CYC == 0)) begin
            idle_d = '0;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end
      end
      FULL: begin
        idle_d = '0;
        if (slot_free) begin
          out_data_d  = acc_q;
          out_len_d   = count_q;
          out_valid_d = 1'b1;
          acc_d       = '0;
          count_d     = '0;
          state_d     = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: accumulator, counters and the output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      acc_q       <= '0;
      idle_q      <= '0;
      out_data_q  <= '0;
      out_len_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      acc_q       <= acc_d;
      idle_q      <= idle_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.out_data  = out_data_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_valid = out_valid_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler. Two instances see identical stimulus:
// dut_a is MSB-first with an 8-cycle timeout, dut_b is LSB-first with no timeout.
module tb_packet_assembler;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       dbg_a, dbg_b;

  int errors = 0;
  int checks = 0;

  packet_assembler_if #(.NUM_BYTE(4)) bus_a ();
  packet_assembler_if #(.NUM_BYTE(4)) bus_b ();

  assign bus_a.in_data   = in_data;
  assign bus_a.in_valid  = in_valid;
  assign bus_a.flush     = flush;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_data   = in_data;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.flush     = flush;
  assign bus_b.out_ready = out_ready;

  packet_assembler #(.NUM_BYTE(4), .MSB_FIRST(1'b1), .TIMEOUT_CYC(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .dbg_state(dbg_a)
  );
  packet_assembler #(.NUM_BYTE(4), .MSB_FIRST(1'b0), .TIMEOUT_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .dbg_state(dbg_b)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic chk_pkt(input string tag, input logic [31:0] exp_a,
                         input logic [31:0] exp_b, input logic [31:0] len);
    chk({tag, "_a_valid"}, 32'(bus_a.out_valid), 32'd1);
    chk({tag, "_a_data"},  bus_a.out_data, exp_a);
    chk({tag, "_a_len"},   32'(bus_a.out_len), len);
    chk({tag, "_b_valid"}, 32'(bus_b.out_valid), 32'd1);
    chk({tag, "_b_data"},  bus_b.out_data, exp_b);
    chk({tag, "_b_len"},   32'(bus_b.out_len), len);
  endtask

  task automatic chk_none(input string tag);
    chk({tag, "_a_valid"}, 32'(bus_a.out_valid), 32'd0);
    chk({tag, "_b_valid"}, 32'(bus_b.out_valid), 32'd0);
  endtask

  initial begin
    // Reset values.
    #2 rst = 1'b1;
    #1;
    chk_none("rst");
    chk("rst_a_data", bus_a.out_data, 32'h0);
    chk("rst_a_len", 32'(bus_a.out_len), 32'd0);
    chk("rst_a_in_ready", 32'(bus_a.in_ready), 32'd1);
    chk("rst_b_in_ready", 32'(bus_b.in_ready), 32'd1);
    chk("rst_a_state", 32'(dbg_a), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full packet, consumer always ready.
    out_ready = 1'b1;
    send(8'h11); send(8'h22); send(8'h33);
    chk_none("full_pre");
    send(8'h44);
    chk_pkt("full", 32'h11223344, 32'h44332211, 32'd4);
    idle();
    chk_none("full_one_cycle");

    // Back-pressure: 8 bytes with the consumer stalled.
    out_ready = 1'b0;
    send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
    chk_pkt("bp_first", 32'hA0A1A2A3, 32'hA3A2A1A0, 32'd4);
    send(8'hA4); send(8'hA5); send(8'hA6);
    chk("bp_a_in_ready_pre", 32'(bus_a.in_ready), 32'd1);
    send(8'hA7);
    chk("bp_a_in_ready_full", 32'(bus_a.in_ready), 32'd0);
    chk("bp_b_in_ready_full", 32'(bus_b.in_ready), 32'd0);
    chk("bp_a_state_full", 32'(dbg_a), 32'd1);
    idle();
    chk_pkt("bp_hold", 32'hA0A1A2A3, 32'hA3A2A1A0, 32'd4);
    chk("bp_a_in_ready_hold", 32'(bus_a.in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk_pkt("bp_second", 32'hA4A5A6A7, 32'hA7A6A5A4, 32'd4);
    chk("bp_a_in_ready_back", 32'(bus_a.in_ready), 32'd1);
    chk("bp_b_in_ready_back", 32'(bus_b.in_ready), 32'd1);
    tick();
    chk_none("bp_drained");

    // Flush of a partial packet.
    send(8'h5A); send(8'h6B);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_pkt("flush2", 32'h5A6B0000, 32'h00006B5A, 32'd2);
    tick();
    chk_none("flush2_after");

    // Flush with nothing collected is ignored.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_none("flush_empty");
    tick();
    chk_none("flush_empty2");

    // Flush together with the filling byte gives one full packet only.
    send(8'hC1); send(8'hC2); send(8'hC3);
    flush = 1'b1;
    send(8'hC4);
    flush = 1'b0;
    chk_pkt("flush_full", 32'hC1C2C3C4, 32'hC4C3C2C1, 32'd4);
    idle();
    chk_none("flush_full_no_empty");
    tick();
    chk_none("flush_full_no_empty2");

    // Idle timeout on dut_a only.
    send(8'h77);
    in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk_none("to_wait");
    end
    tick();
    chk("to_a_valid", 32'(bus_a.out_valid), 32'd1);
    chk("to_a_data", bus_a.out_data, 32'h77000000);
    chk("to_a_len", 32'(bus_a.out_len), 32'd1);
    chk("to_b_valid", 32'(bus_b.out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_none("to_after");
    end

    // Asynchronous reset mid-packet discards the partial packet.
    send(8'h55); send(8'h66);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk_none("arst");
    chk("arst_a_data", bus_a.out_data, 32'h0);
    chk("arst_b_data", bus_b.out_data, 32'h0);
    chk("arst_a_len", 32'(bus_a.out_len), 32'd0);
    chk("arst_a_in_ready", 32'(bus_a.in_ready), 32'd1);
    #1 rst = 1'b0;
    tick();
    send(8'h01); send(8'h02); send(8'h03);
    chk_none("post_rst_pre");
    send(8'h04);
    chk_pkt("post_rst", 32'h01020304, 32'h04030201, 32'd4);
    idle();
    chk_none("post_rst_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
